// File: rtl/prom_loader.sv
// Byte-stream program-memory loader: count byte, N hi/lo word pairs, optional checksum (LOADER_CSUM_EN).
// Latency: write strobe one cycle after the low byte is accepted; at least 3 cycles per word.
// Backpressure: din_ready is high only in byte-consuming states; the loader stalls indefinitely on din_valid=0.
module prom_loader (
    input  logic        clk_ld,
    input  logic        rst_n_ld,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        prom_we,
    output logic [7:0]  prom_addr,
    output logic [14:0] prom_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CNT  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WR   = 3'd4,
`ifdef LOADER_CSUM_EN
        S_CHK  = 3'd5,
`endif
        S_FIN  = 3'd6,
        S_FAIL = 3'd7
    } state_t;

    state_t     state;
    logic [7:0] word_cnt;
    logic [7:0] word_num;
    logic [6:0] hi_byte;
    logic       take;
    logic       last_word;

`ifdef LOADER_CSUM_EN
    logic [7:0] csum;
`endif

    assign take      = din_valid & din_ready;
    // N=0 encodes 256 words, so the terminal index is N-1 taken modulo 256.
    assign last_word = (word_cnt == (word_num - 8'd1));

    always_ff @(posedge clk_ld or negedge rst_n_ld) begin
        if (!rst_n_ld) begin
            state     <= S_IDLE;
            word_cnt  <= 8'd0;
            word_num  <= 8'd0;
            hi_byte   <= 7'd0;
            din_ready <= 1'b0;
            prom_we   <= 1'b0;
            prom_addr <= 8'd0;
            prom_din  <= 15'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            prom_we <= 1'b0;
            case (state)
                S_IDLE, S_FIN, S_FAIL: begin
                    if (start) begin
                        state     <= S_CNT;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        din_ready <= 1'b1;
                    end
                end

                S_CNT: begin
                    if (take) begin
                        word_num <= din;
                        word_cnt <= 8'd0;
`ifdef LOADER_CSUM_EN
                        csum     <= 8'd0;
`endif
                        state    <= S_HI;
                    end
                end

                S_HI: begin
                    if (take) begin
                        if (din[7]) begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                            din_ready <= 1'b0;
                        end else begin
                            hi_byte <= din[6:0];
`ifdef LOADER_CSUM_EN
                            csum    <= csum ^ din;
`endif
                            state   <= S_LO;
                        end
                    end
                end

                S_LO: begin
                    if (take) begin
                        // The low byte lands straight in prom_din; it doubles as the low data latch.
                        prom_we   <= 1'b1;
                        prom_addr <= word_cnt;
                        prom_din  <= {hi_byte, din};
`ifdef LOADER_CSUM_EN
                        csum      <= csum ^ din;
`endif
                        din_ready <= 1'b0;
                        state     <= S_WR;
                    end
                end

                S_WR: begin
                    if (last_word) begin
`ifdef LOADER_CSUM_EN
                        state     <= S_CHK;
                        din_ready <= 1'b1;
`else
                        state     <= S_FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        word_cnt  <= word_cnt + 8'd1;
                        state     <= S_HI;
                        din_ready <= 1'b1;
                    end
                end

`ifdef LOADER_CSUM_EN
                S_CHK: begin
                    if (take) begin
                        din_ready <= 1'b0;
                        busy      <= 1'b0;
                        if (din == csum) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FAIL;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    din_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prom_loader.sv
// Self-checking bench for prom_loader: randomized byte streams against a stream-level reference model.
module tb_prom_loader;

    logic        clk_ld = 1'b0;
    logic        rst_n_ld = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        prom_we;
    logic [7:0]  prom_addr;
    logic [14:0] prom_din;
    logic        busy;
    logic        done;
    logic        err;

    prom_loader dut (
        .clk_ld    (clk_ld),
        .rst_n_ld  (rst_n_ld),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .prom_we   (prom_we),
        .prom_addr (prom_addr),
        .prom_din  (prom_din),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_ld = ~clk_ld;

    int tests = 0;
    int fails = 0;

    logic [7:0] stim[$];
    int         m_addr[$];
    int         m_data[$];
    bit         m_err;
    int         m_used;

    int         w_addr[$];
    int         w_data[$];

    always @(negedge clk_ld) begin
        if (prom_we === 1'b1) begin
            w_addr.push_back(int'(prom_addr));
            w_data.push_back(int'(prom_din));
        end
    end

    // Reference: interpret the stream word by word and decide writes, outcome, bytes consumed.
    task automatic model_session();
        int n;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] x = 8'd0;
        m_addr.delete();
        m_data.delete();
        m_err  = 1'b0;
        m_used = 1;
        n = (stim[0] == 8'd0) ? 256 : int'(stim[0]);
        for (int i = 0; i < n; i++) begin
            hi = stim[m_used];
            m_used++;
            if (hi[7]) begin
                m_err = 1'b1;
                return;
            end
            lo = stim[m_used];
            m_used++;
            m_addr.push_back(i);
            m_data.push_back(int'(hi[6:0]) * 256 + int'(lo));
            x = x ^ hi ^ lo;
        end
`ifdef LOADER_CSUM_EN
        if (stim[m_used] != x) m_err = 1'b1;
        m_used++;
`endif
    endtask

    task automatic build_stream(input int n_words, input int bad_hi_at, input bit bad_csum);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] x = 8'd0;
        stim.delete();
        stim.push_back(8'(n_words));
        for (int i = 0; i < n_words; i++) begin
            hi = 8'($urandom_range(127, 0));
            lo = 8'($urandom);
            if (i == bad_hi_at) hi[7] = 1'b1;
            x = x ^ hi ^ lo;
            stim.push_back(hi);
            stim.push_back(lo);
        end
        if (bad_csum) x = x ^ 8'($urandom_range(255, 1));
        stim.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_ld);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        int waitc = 0;
        repeat (gap) begin
            din       = 8'($urandom);
            din_valid = 1'b0;
            @(negedge clk_ld);
        end
        din       = b;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk_ld);
            waitc++;
        end
        ok = (din_ready === 1'b1);
        if (ok) @(negedge clk_ld);
        din_valid = 1'b0;
    endtask

    task automatic run_session(input string name, input int max_gap, input int start_at);
        bit ok;
        int waitc = 0;
        int bad = 0;
        int first_bad = -1;
        model_session();
        w_addr.delete();
        w_data.delete();
        pulse_start();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        for (int k = 0; k < m_used; k++) begin
            if (k == start_at) pulse_start();
            send_byte(stim[k], max_gap, ok);
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL %s byte_timeout: byte %0d not accepted, expected acceptance", name, k);
                break;
            end
        end
        while (busy !== 1'b0 && waitc < 10) begin
            @(negedge clk_ld);
            waitc++;
        end
        tests++;
        if (w_addr.size() != m_addr.size()) begin
            fails++;
            $display("FAIL %s write_count: got %0d expected %0d", name, w_addr.size(), m_addr.size());
        end
        tests++;
        for (int i = 0; i < m_addr.size() && i < w_addr.size(); i++) begin
            if (w_addr[i] != m_addr[i] || w_data[i] != m_data[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0) begin
            fails++;
            $display("FAIL %s write_content: word %0d got addr %0h data %0h expected addr %0h data %0h",
                     name, first_bad, w_addr[first_bad], w_data[first_bad], m_addr[first_bad], m_data[first_bad]);
        end
        tests++;
        if (done !== !m_err || err !== m_err || busy !== 1'b0 || din_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s outcome: got done=%b err=%b busy=%b rdy=%b expected done=%b err=%b busy=0 rdy=0",
                     name, done, err, busy, din_ready, !m_err, m_err);
        end
        if (m_addr.size() > 0) begin
            tests++;
            if (prom_addr !== 8'(m_addr[$]) || prom_din !== 15'(m_data[$])) begin
                fails++;
                $display("FAIL %s hold_last: got addr %0h data %0h expected addr %0h data %0h",
                         name, prom_addr, prom_din, m_addr[$], m_data[$]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if (din_ready !== 1'b0 || prom_we !== 1'b0 || prom_addr !== 8'd0 || prom_din !== 15'd0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h din=%h busy=%b done=%b err=%b expected all zero",
                     name, din_ready, prom_we, prom_addr, prom_din, busy, done, err);
        end
    endtask

    task automatic test_reset();
        rst_n_ld = 1'b0;
        repeat (2) @(negedge clk_ld);
        tests++;
        if (prom_we !== 1'b0 || din_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: got we=%b rdy=%b expected 0 0", prom_we, din_ready);
        end
        check_idle_outputs("reset_outputs");
        rst_n_ld = 1'b1;
        repeat (2) @(negedge clk_ld);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        stim = '{8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hD9};
        run_session("basic", 0, -1);
        tests++;
        if (w_data.size() != 2 || w_data[0] != 'h1234 || w_data[1] != 'h00FF) begin
            fails++;
            $display("FAIL basic_words: got %0d writes expected 1234,00FF", w_data.size());
        end
`ifdef LOADER_CSUM_EN
        stim = '{8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h00};
        run_session("bad_csum", 0, -1);
        tests++;
        if (err !== 1'b1 || w_data.size() != 2) begin
            fails++;
            $display("FAIL bad_csum_err: got err=%b writes=%0d expected err=1 writes=2", err, w_data.size());
        end
`endif
    endtask

    task automatic test_hi_bit7();
        stim = '{8'h01, 8'h80, 8'h00, 8'h80};
        run_session("hi_bit7", 0, -1);
        tests++;
        if (err !== 1'b1 || w_addr.size() != 0) begin
            fails++;
            $display("FAIL hi_bit7_err: got err=%b writes=%0d expected err=1 writes=0", err, w_addr.size());
        end
    endtask

    task automatic test_n_zero();
        logic [7:0] x = 8'd0;
        stim.delete();
        stim.push_back(8'h00);
        for (int a = 0; a < 256; a++) begin
            stim.push_back(8'h00);
            stim.push_back(8'(a));
            x = x ^ 8'(a);
        end
        stim.push_back(x);
        run_session("n_zero", 0, -1);
        tests++;
        if (w_addr.size() != 256 || done !== 1'b1) begin
            fails++;
            $display("FAIL n_zero_count: got %0d writes done=%b expected 256 done=1", w_addr.size(), done);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        w_addr.delete();
        w_data.delete();
        pulse_start();
        send_byte(8'h01, 0, ok);
        send_byte(8'h2A, 0, ok);
        repeat (5) begin
            din = 8'($urandom);
            @(negedge clk_ld);
            if (din_ready !== 1'b1 || prom_we !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
        end
        send_byte(8'h5C, 0, ok);
        tests++;
        if (!ok || prom_we !== 1'b1 || prom_addr !== 8'h00 || prom_din !== 15'h2A5C) begin
            fails++;
            $display("FAIL stall_write: got we=%b addr=%h din=%h expected we=1 addr=00 din=2a5c",
                     prom_we, prom_addr, prom_din);
        end
`ifdef LOADER_CSUM_EN
        send_byte(8'h2A ^ 8'h5C, 0, ok);
`else
        @(negedge clk_ld);
`endif
        tests++;
        if (done !== 1'b1 || w_addr.size() != 1) begin
            fails++;
            $display("FAIL stall_done: got done=%b writes=%0d expected done=1 writes=1", done, w_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_start();
        send_byte(8'h03, 0, ok);
        send_byte(8'h11, 0, ok);
        w_addr.delete();
        rst_n_ld = 1'b0;
        #1;
        check_idle_outputs("reset_mid_outputs");
        @(negedge clk_ld);
        rst_n_ld = 1'b1;
        din       = 8'h22;
        din_valid = 1'b1;
        repeat (4) @(negedge clk_ld);
        din_valid = 1'b0;
        tests++;
        if (w_addr.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got writes=%0d busy=%b expected 0 0", w_addr.size(), busy);
        end
        build_stream(3, -1, 1'b0);
        run_session("reset_mid_fresh", 1, -1);
    endtask

    task automatic test_random();
        int n;
        int bad_at;
        bit bad_cs;
        for (int s = 0; s < 14; s++) begin
            n      = $urandom_range(6, 1);
            bad_at = ($urandom_range(5, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
            bad_cs = ($urandom_range(3, 0) == 0);
            build_stream(n, bad_at, bad_cs);
            run_session($sformatf("random%0d", s), 3,
                        ($urandom_range(1, 0) == 1) ? $urandom_range(2 * n, 1) : -1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_ld);
        test_reset();
        test_basic();
        test_hi_bit7();
        test_stall();
        test_n_zero();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
